// File: rtl/cam_pkg.sv
// Shared enums and default widths for the CAM allocation front-end.
package cam_pkg;
   localparam int CAM_DATA_WIDTH = 32;
   localparam int CAM_ADDR_WIDTH = 5;
   localparam logic [CAM_DATA_WIDTH-1:0] CAM_TOMBSTONE = '1;

   typedef enum logic [1:0] {RSVD = 2'd0, INSERT = 2'd1, DELETE = 2'd2, LOOKUP = 2'd3} op_e;
   typedef enum logic [2:0] {OK = 3'd0, DUP = 3'd1, FULL = 3'd2, MISS = 3'd3, ERR = 3'd4} status_e;
   typedef enum logic [2:0] {INIT, IDLE, SRCH, WAIT, WR, DEL, RESP} state_e;
endpackage

// File: rtl/cam_free_finder.sv
// Lowest-clear-bit encoder over the CAM valid bitmap.
module cam_free_finder
   import cam_pkg::*;
#(
   parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
   parameter int DEPTH      = 1 << ADDR_WIDTH
) (
   input  logic [DEPTH-1:0]      valid_map,
   output logic [ADDR_WIDTH-1:0] free_index,
   output logic                  any_free
);
   // Scan from the top so the lowest clear bit is the last one to win.
   always_comb begin
      free_index = '0;
      any_free   = 1'b0;
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (!valid_map[i]) begin
            free_index = ADDR_WIDTH'(i);
            any_free   = 1'b1;
         end
      end
   end
endmodule

// File: rtl/cam_alloc_ctrl.sv
// Command front-end for the CAM: tombstone sweep after reset, insert/delete/lookup
// sequencing, lowest-free allocation and one response per accepted command.
module cam_alloc_ctrl
   import cam_pkg::*;
#(
   parameter int DATA_WIDTH = CAM_DATA_WIDTH,
   parameter int ADDR_WIDTH = CAM_ADDR_WIDTH,
   parameter int DEPTH      = 1 << ADDR_WIDTH,
   parameter int SEARCH_LAT = 1,
   parameter logic [DATA_WIDTH-1:0] TOMBSTONE = {DATA_WIDTH{1'b1}}
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [1:0]            cmd_op_i,
   input  logic [DATA_WIDTH-1:0] cmd_data_i,
   input  logic [ADDR_WIDTH-1:0] cmd_index_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [2:0]            rsp_status_o,
   output logic [ADDR_WIDTH-1:0] rsp_index_o,
   output logic                  cam_write_o,
   output logic [ADDR_WIDTH-1:0] cam_write_index_o,
   output logic [DATA_WIDTH-1:0] cam_write_data_o,
   output logic                  cam_search_o,
   output logic [DATA_WIDTH-1:0] cam_search_data_o,
   input  logic                  cam_search_valid_i,
   input  logic [ADDR_WIDTH-1:0] cam_search_index_i,
   output logic                  busy_o,
   output logic [ADDR_WIDTH:0]   occupancy_o
);
   localparam int WCW = (SEARCH_LAT > 1) ? $clog2(SEARCH_LAT) : 1;

   state_e                state, state_n;
   logic [ADDR_WIDTH:0]   init_cnt, init_n;
   logic [WCW-1:0]        wait_cnt, wait_n;
   op_e                   op_q, op_n;
   logic [ADDR_WIDTH-1:0] idx_q, idx_n;
   logic [DEPTH-1:0]      valid_map, map_n;
   logic [ADDR_WIDTH:0]   occ_n;
   status_e               rsp_status, rstat_n;
   logic                  ready_n, rvld_n, wr_n, srch_n;
   logic [ADDR_WIDTH-1:0] ridx_n, widx_n;
   logic [DATA_WIDTH-1:0] wdata_n, sdata_n;
   logic [ADDR_WIDTH-1:0] free_index;
   logic                  any_free;
   op_e                   cmd_op;

   cam_free_finder #(.ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH)) u_free (
      .valid_map  (valid_map),
      .free_index (free_index),
      .any_free   (any_free)
   );

   assign cmd_op       = op_e'(cmd_op_i);
   assign rsp_status_o = rsp_status;
   assign busy_o       = (state != IDLE);

   // All strobes and response fields are registered: next values are decided here.
   always_comb begin
      state_n = state;
      init_n  = init_cnt;
      wait_n  = wait_cnt;
      op_n    = op_q;
      idx_n   = idx_q;
      map_n   = valid_map;
      occ_n   = occupancy_o;
      ready_n = 1'b0;
      rvld_n  = rsp_valid_o;
      rstat_n = rsp_status;
      ridx_n  = rsp_index_o;
      wr_n    = 1'b0;
      widx_n  = cam_write_index_o;
      wdata_n = cam_write_data_o;
      srch_n  = 1'b0;
      sdata_n = cam_search_data_o;
      case (state)
         INIT: begin
            if (init_cnt == (ADDR_WIDTH+1)'(DEPTH)) begin
               state_n = IDLE;
               ready_n = 1'b1;
            end else begin
               wr_n    = 1'b1;
               widx_n  = init_cnt[ADDR_WIDTH-1:0];
               wdata_n = TOMBSTONE;
               init_n  = init_cnt + 1'b1;
            end
         end
         IDLE: begin
            ready_n = 1'b1;
            if (cmd_valid_i && cmd_ready_o) begin
               ready_n = 1'b0;
               op_n    = cmd_op;
               idx_n   = cmd_index_i;
               if (cmd_op == RSVD || (cmd_op != DELETE && cmd_data_i == TOMBSTONE)) begin
                  state_n = RESP;
                  rvld_n  = 1'b1;
                  rstat_n = ERR;
                  ridx_n  = '0;
               end else if (cmd_op == DELETE) begin
                  // The tombstone write goes out in the DEL cycle only for a live entry.
                  state_n = DEL;
                  if (valid_map[cmd_index_i]) begin
                     wr_n    = 1'b1;
                     widx_n  = cmd_index_i;
                     wdata_n = TOMBSTONE;
                  end
               end else begin
                  state_n = SRCH;
                  srch_n  = 1'b1;
                  sdata_n = cmd_data_i;
               end
            end
         end
         SRCH: begin
            state_n = WAIT;
            wait_n  = '0;
         end
         WAIT: begin
            if (wait_cnt == WCW'(SEARCH_LAT-1)) begin
               state_n = RESP;
               rvld_n  = 1'b1;
               ridx_n  = '0;
               if (cam_search_valid_i) begin
                  rstat_n = (op_q == LOOKUP) ? OK : DUP;
                  ridx_n  = cam_search_index_i;
               end else if (op_q == LOOKUP) begin
                  rstat_n = MISS;
               end else if (!any_free) begin
                  rstat_n = FULL;
               end else begin
                  state_n = WR;
                  rvld_n  = 1'b0;
                  wr_n    = 1'b1;
                  widx_n  = free_index;
                  wdata_n = cam_search_data_o;
               end
            end else begin
               wait_n = wait_cnt + 1'b1;
            end
         end
         WR: begin
            map_n[cam_write_index_o] = 1'b1;
            occ_n   = occupancy_o + 1'b1;
            state_n = RESP;
            rvld_n  = 1'b1;
            rstat_n = OK;
            ridx_n  = cam_write_index_o;
         end
         DEL: begin
            state_n = RESP;
            rvld_n  = 1'b1;
            ridx_n  = idx_q;
            if (valid_map[idx_q]) begin
               map_n[idx_q] = 1'b0;
               occ_n   = occupancy_o - 1'b1;
               rstat_n = OK;
            end else begin
               rstat_n = MISS;
            end
         end
         RESP: begin
            if (rsp_ready_i) begin
               state_n = IDLE;
               ready_n = 1'b1;
               rvld_n  = 1'b0;
               rstat_n = OK;
               ridx_n  = '0;
            end
         end
         default: state_n = INIT;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state             <= INIT;
         init_cnt          <= '0;
         wait_cnt          <= '0;
         op_q              <= RSVD;
         idx_q             <= '0;
         valid_map         <= '0;
         occupancy_o       <= '0;
         cmd_ready_o       <= 1'b0;
         rsp_valid_o       <= 1'b0;
         rsp_status        <= OK;
         rsp_index_o       <= '0;
         cam_write_o       <= 1'b0;
         cam_write_index_o <= '0;
         cam_write_data_o  <= '0;
         cam_search_o      <= 1'b0;
         cam_search_data_o <= '0;
      end else begin
         state             <= state_n;
         init_cnt          <= init_n;
         wait_cnt          <= wait_n;
         op_q              <= op_n;
         idx_q             <= idx_n;
         valid_map         <= map_n;
         occupancy_o       <= occ_n;
         cmd_ready_o       <= ready_n;
         rsp_valid_o       <= rvld_n;
         rsp_status        <= rstat_n;
         rsp_index_o       <= ridx_n;
         cam_write_o       <= wr_n;
         cam_write_index_o <= widx_n;
         cam_write_data_o  <= wdata_n;
         cam_search_o      <= srch_n;
         cam_search_data_o <= sdata_n;
      end
   end
endmodule
